wb_mem_arb: RTL and testbench

- Two-master Wishbone arbiter and address decoder that sits directly upstream of the ExoTiny QSPI ROM/RAM adapter.
- Merges the CPU instruction bus (ibus) and data bus (dbus) into the adapter's single Wishbone port.
- Decodes ROM vs RAM and drives the adapter's ROM/RAM select, holding it stable for the whole access.
- Filters illegal ROM writes and serves repeated instruction fetches from a one-entry fetch buffer.

---
 rtl/wb_mem_arb_if.sv | 46 ++++
 rtl/wb_mem_arb.sv | 148 ++++++++++++++
 tb/tb_wb_mem_arb.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_mem_arb_if.sv
// Bus bundle between the CPU ibus/dbus, the arbiter and the QSPI ROM/RAM adapter.
// slave is the arbiter's view; master is the surrounding CPU + adapter environment.
interface wb_mem_arb_if;
  logic        wb_ibus_stb_i;
  logic [31:0] wb_ibus_adr_i;
  logic        wb_ibus_ack_o;
  logic [31:0] wb_ibus_dat_o;

  logic        wb_dbus_stb_i;
  logic        wb_dbus_we_i;
  logic [3:0]  wb_dbus_be_i;
  logic [31:0] wb_dbus_adr_i;
  logic [31:0] wb_dbus_dat_i;
  logic        wb_dbus_ack_o;
  logic [31:0] wb_dbus_dat_o;

  logic        sel_rom_ram_o;
  logic        wb_mem_stb_o;
  logic        wb_mem_we_o;
  logic [3:0]  wb_mem_be_o;
  logic [21:0] wb_mem_adr_o;
  logic [31:0] wb_mem_dat_o;
  logic [31:0] wb_mem_dat_i;
  logic        wb_mem_ack_i;
  logic        rom_wr_err_o;

  modport slave (
    input  wb_ibus_stb_i, wb_ibus_adr_i,
    output wb_ibus_ack_o, wb_ibus_dat_o,
    input  wb_dbus_stb_i, wb_dbus_we_i, wb_dbus_be_i, wb_dbus_adr_i, wb_dbus_dat_i,
    output wb_dbus_ack_o, wb_dbus_dat_o,
    output sel_rom_ram_o, wb_mem_stb_o, wb_mem_we_o, wb_mem_be_o, wb_mem_adr_o, wb_mem_dat_o,
    input  wb_mem_dat_i, wb_mem_ack_i,
    output rom_wr_err_o
  );

  modport master (
    output wb_ibus_stb_i, wb_ibus_adr_i,
    input  wb_ibus_ack_o, wb_ibus_dat_o,
    output wb_dbus_stb_i, wb_dbus_we_i, wb_dbus_be_i, wb_dbus_adr_i, wb_dbus_dat_i,
    input  wb_dbus_ack_o, wb_dbus_dat_o,
    input  sel_rom_ram_o, wb_mem_stb_o, wb_mem_we_o, wb_mem_be_o, wb_mem_adr_o, wb_mem_dat_o,
    output wb_mem_dat_i, wb_mem_ack_i,
    input  rom_wr_err_o
  );
endinterface

// File: rtl/wb_mem_arb.sv
// Two-master Wishbone arbiter/decoder in front of the QSPI ROM/RAM adapter,
// with ROM-write filtering and a one-entry instruction fetch buffer.
//
// state | meaning
// IDLE  | evaluate requests, nothing outstanding downstream
// BUSY  | downstream access in flight, request registers held
// HIT   | ibus served from the fetch buffer (ack this cycle)
// DROP  | dbus write to ROM discarded (ack this cycle, error flagged)
module wb_mem_arb #(
  parameter int RAM_SEL_BIT = 24,
  parameter bit USE_IBUF    = 1'b1
) (
  input logic          clk_i,
  input logic          rst_in,
  wb_mem_arb_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HIT, S_DROP} state_t;

  state_t      r_state;
  logic        r_last_dbus;
  logic        r_gnt_dbus;
  logic        r_hit_ack;
  logic        r_drop_ack;
  logic        r_rom_wr_err;
  logic        r_mem_stb;
  logic        r_mem_we;
  logic [3:0]  r_mem_be;
  logic [21:0] r_mem_adr;
  logic [31:0] r_mem_dat;
  logic        r_sel;
  logic        r_buf_valid;
  logic [22:0] r_buf_tag;
  logic [31:0] r_buf_dat;

  logic [22:0] w_i_tag;
  logic [22:0] w_d_tag;
  logic        w_drop;
  logic        w_i_hit;
  logic        w_pick_dbus;
  logic        w_mem_ack;
  logic        w_ibus_ack;
  logic        w_dbus_ack;
  logic        w_unused_adr;

  // Tag is {sel, word address}, so ROM and RAM aliases never match each other.
  assign w_i_tag = {bus.wb_ibus_adr_i[RAM_SEL_BIT], bus.wb_ibus_adr_i[23:2]};
  assign w_d_tag = {bus.wb_dbus_adr_i[RAM_SEL_BIT], bus.wb_dbus_adr_i[23:2]};
  assign w_unused_adr = ^{bus.wb_ibus_adr_i[31:24], bus.wb_ibus_adr_i[1:0],
                          bus.wb_dbus_adr_i[31:24], bus.wb_dbus_adr_i[1:0]};

  assign w_drop      = bus.wb_dbus_stb_i && bus.wb_dbus_we_i && !w_d_tag[22];
  assign w_i_hit     = USE_IBUF && r_buf_valid && bus.wb_ibus_stb_i && (r_buf_tag == w_i_tag)
                       && (!bus.wb_dbus_stb_i || r_last_dbus);
  assign w_pick_dbus = bus.wb_dbus_stb_i && (!bus.wb_ibus_stb_i || !r_last_dbus);
  assign w_mem_ack   = (r_state == S_BUSY) && bus.wb_mem_ack_i;

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      r_state      <= S_IDLE;
      r_last_dbus  <= 1'b1;
      r_gnt_dbus   <= 1'b0;
      r_hit_ack    <= 1'b0;
      r_drop_ack   <= 1'b0;
      r_rom_wr_err <= 1'b0;
      r_mem_stb    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'h0;
      r_mem_adr    <= 22'h0;
      r_mem_dat    <= 32'h0;
      r_sel        <= 1'b0;
      r_buf_valid  <= 1'b0;
      r_buf_tag    <= 23'h0;
      r_buf_dat    <= 32'h0;
    end else begin
      r_hit_ack  <= 1'b0;
      r_drop_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_drop) begin
            r_state      <= S_DROP;
            r_drop_ack   <= 1'b1;
            r_rom_wr_err <= 1'b1;
            r_last_dbus  <= 1'b1;
          end else if (w_i_hit) begin
            r_state     <= S_HIT;
            r_hit_ack   <= 1'b1;
            r_last_dbus <= 1'b0;
          end else if (w_pick_dbus) begin
            r_state     <= S_BUSY;
            r_mem_stb   <= 1'b1;
            r_gnt_dbus  <= 1'b1;
            r_last_dbus <= 1'b1;
            r_mem_we    <= bus.wb_dbus_we_i;
            r_mem_be    <= bus.wb_dbus_be_i;
            r_mem_adr   <= w_d_tag[21:0];
            r_mem_dat   <= bus.wb_dbus_dat_i;
            r_sel       <= w_d_tag[22];
            // Only RAM writes reach here; a write to the buffered word makes it stale.
            if (bus.wb_dbus_we_i && (w_d_tag == r_buf_tag))
              r_buf_valid <= 1'b0;
          end else if (bus.wb_ibus_stb_i) begin
            r_state     <= S_BUSY;
            r_mem_stb   <= 1'b1;
            r_gnt_dbus  <= 1'b0;
            r_last_dbus <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'hF;
            r_mem_adr   <= w_i_tag[21:0];
            r_mem_dat   <= 32'h0;
            r_sel       <= w_i_tag[22];
          end
        end
        S_BUSY: begin
          if (bus.wb_mem_ack_i) begin
            r_state   <= S_IDLE;
            r_mem_stb <= 1'b0;
            if (USE_IBUF && !r_gnt_dbus) begin
              r_buf_valid <= 1'b1;
              r_buf_tag   <= {r_sel, r_mem_adr};
              r_buf_dat   <= bus.wb_mem_dat_i;
            end
          end
        end
        S_HIT:   r_state <= S_IDLE;
        S_DROP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_ibus_ack = bus.wb_ibus_stb_i && (r_hit_ack || (w_mem_ack && !r_gnt_dbus));
  assign w_dbus_ack = bus.wb_dbus_stb_i && (r_drop_ack || (w_mem_ack && r_gnt_dbus));

  assign bus.wb_ibus_ack_o = w_ibus_ack;
  assign bus.wb_dbus_ack_o = w_dbus_ack;
  assign bus.wb_ibus_dat_o = !w_ibus_ack ? 32'h0 : (r_hit_ack ? r_buf_dat : bus.wb_mem_dat_i);
  assign bus.wb_dbus_dat_o = (w_dbus_ack && !r_drop_ack) ? bus.wb_mem_dat_i : 32'h0;

  assign bus.sel_rom_ram_o = r_sel;
  assign bus.wb_mem_stb_o  = r_mem_stb;
  assign bus.wb_mem_we_o   = r_mem_we;
  assign bus.wb_mem_be_o   = r_mem_be;
  assign bus.wb_mem_adr_o  = r_mem_adr;
  assign bus.wb_mem_dat_o  = r_mem_dat;
  assign bus.rom_wr_err_o  = r_rom_wr_err;

endmodule

// File: tb/tb_wb_mem_arb.sv
// Directed bench for wb_mem_arb: the bench plays both CPU masters and the adapter.
module tb_wb_mem_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  wb_mem_arb_if bus();

  wb_mem_arb #(.RAM_SEL_BIT(24), .USE_IBUF(1'b1)) dut (
    .clk_i (clk),
    .rst_in(rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.wb_ibus_stb_i = 1'b0;
    bus.wb_ibus_adr_i = 32'h0;
    bus.wb_dbus_stb_i = 1'b0;
    bus.wb_dbus_we_i  = 1'b0;
    bus.wb_dbus_be_i  = 4'h0;
    bus.wb_dbus_adr_i = 32'h0;
    bus.wb_dbus_dat_i = 32'h0;
    bus.wb_mem_dat_i  = 32'h0;
    bus.wb_mem_ack_i  = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_stb",      bus.wb_mem_stb_o,  0);
    chk("rst_iack",     bus.wb_ibus_ack_o, 0);
    chk("rst_dack",     bus.wb_dbus_ack_o, 0);
    chk("rst_idat",     bus.wb_ibus_dat_o, 0);
    chk("rst_ddat",     bus.wb_dbus_dat_o, 0);
    chk("rst_err",      bus.rom_wr_err_o,  0);
    chk("rst_adr",      bus.wb_mem_adr_o,  0);
    rst_n = 1'b1;
    tick();

    // ibus fetch ROM 0x100 goes downstream
    bus.wb_ibus_stb_i = 1'b1;
    bus.wb_ibus_adr_i = 32'h0000_0100;
    tick();
    chk("f1_stb",  bus.wb_mem_stb_o,  1);
    chk("f1_sel",  bus.sel_rom_ram_o, 0);
    chk("f1_adr",  bus.wb_mem_adr_o,  32'h40);
    chk("f1_be",   bus.wb_mem_be_o,   4'hF);
    chk("f1_we",   bus.wb_mem_we_o,   0);
    chk("f1_iack0", bus.wb_ibus_ack_o, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("f1_stb_hold", bus.wb_mem_stb_o, 1);
    end
    bus.wb_mem_dat_i = 32'h1234_5678;
    bus.wb_mem_ack_i = 1'b1;
    #1;
    chk("f1_iack", bus.wb_ibus_ack_o, 1);
    chk("f1_idat", bus.wb_ibus_dat_o, 32'h1234_5678);
    chk("f1_dack", bus.wb_dbus_ack_o, 0);
    chk("f1_ddat", bus.wb_dbus_dat_o, 0);
    tick();
    bus.wb_mem_ack_i = 1'b0;
    bus.wb_ibus_stb_i = 1'b0;
    bus.wb_mem_dat_i = 32'hFFFF_0000;
    chk("f1_stb_off", bus.wb_mem_stb_o, 0);
    tick();

    // repeat fetch hits the buffer: ack on the cycle after the strobe is sampled
    bus.wb_ibus_stb_i = 1'b1;
    bus.wb_ibus_adr_i = 32'h0000_0100;
    #1;
    chk("h1_iack_early", bus.wb_ibus_ack_o, 0);
    tick();
    chk("h1_iack", bus.wb_ibus_ack_o, 1);
    chk("h1_idat", bus.wb_ibus_dat_o, 32'h1234_5678);
    chk("h1_stb",  bus.wb_mem_stb_o,  0);
    tick();
    bus.wb_ibus_stb_i = 1'b0;
    chk("h1_stb2", bus.wb_mem_stb_o, 0);
    chk("h1_iack_off", bus.wb_ibus_ack_o, 0);
    tick();

    // dbus sw to RAM
    bus.wb_dbus_stb_i = 1'b1;
    bus.wb_dbus_we_i  = 1'b1;
    bus.wb_dbus_be_i  = 4'hF;
    bus.wb_dbus_adr_i = 32'h0100_0010;
    bus.wb_dbus_dat_i = 32'hDEAD_BEEF;
    tick();
    chk("w1_sel", bus.sel_rom_ram_o, 1);
    chk("w1_adr", bus.wb_mem_adr_o,  32'h4);
    chk("w1_we",  bus.wb_mem_we_o,   1);
    chk("w1_be",  bus.wb_mem_be_o,   4'hF);
    chk("w1_dat", bus.wb_mem_dat_o,  32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w1_stb_hold", bus.wb_mem_stb_o, 1);
      chk("w1_sel_hold", bus.sel_rom_ram_o, 1);
      chk("w1_adr_hold", bus.wb_mem_adr_o, 32'h4);
    end
    bus.wb_mem_ack_i = 1'b1;
    #1;
    chk("w1_dack", bus.wb_dbus_ack_o, 1);
    chk("w1_iack", bus.wb_ibus_ack_o, 0);
    tick();
    bus.wb_mem_ack_i = 1'b0;
    bus.wb_dbus_stb_i = 1'b0;
    chk("w1_stb_off", bus.wb_mem_stb_o, 0);
    tick();

    // dbus sb to ROM is dropped
    bus.wb_dbus_stb_i = 1'b1;
    bus.wb_dbus_we_i  = 1'b1;
    bus.wb_dbus_be_i  = 4'b0001;
    bus.wb_dbus_adr_i = 32'h0000_0004;
    bus.wb_dbus_dat_i = 32'h0000_00AA;
    tick();
    chk("d1_dack", bus.wb_dbus_ack_o, 1);
    chk("d1_ddat", bus.wb_dbus_dat_o, 0);
    chk("d1_stb",  bus.wb_mem_stb_o,  0);
    chk("d1_err",  bus.rom_wr_err_o,  1);
    tick();
    bus.wb_dbus_stb_i = 1'b0;
    bus.wb_dbus_we_i  = 1'b0;
    chk("d1_dack_off", bus.wb_dbus_ack_o, 0);
    chk("d1_stb2", bus.wb_mem_stb_o, 0);
    tick(); tick();
    chk("d1_err_sticky", bus.rom_wr_err_o, 1);

    // hit again so ibus is last granted before the contention test
    bus.wb_ibus_stb_i = 1'b1;
    bus.wb_ibus_adr_i = 32'h0000_0100;
    tick();
    chk("h2_iack", bus.wb_ibus_ack_o, 1);
    tick();
    bus.wb_ibus_stb_i = 1'b0;
    tick();

    // simultaneous requests: dbus first, then ibus, with a gap between
    bus.wb_ibus_stb_i = 1'b1;
    bus.wb_ibus_adr_i = 32'h0000_0200;
    bus.wb_dbus_stb_i = 1'b1;
    bus.wb_dbus_we_i  = 1'b0;
    bus.wb_dbus_be_i  = 4'hF;
    bus.wb_dbus_adr_i = 32'h0100_0040;
    tick();
    chk("c1_stb", bus.wb_mem_stb_o, 1);
    chk("c1_sel", bus.sel_rom_ram_o, 1);
    chk("c1_adr", bus.wb_mem_adr_o, 32'h10);
    chk("c1_we",  bus.wb_mem_we_o, 0);
    tick();
    bus.wb_mem_dat_i = 32'hCAFE_0001;
    bus.wb_mem_ack_i = 1'b1;
    #1;
    chk("c1_dack", bus.wb_dbus_ack_o, 1);
    chk("c1_ddat", bus.wb_dbus_dat_o, 32'hCAFE_0001);
    chk("c1_iack", bus.wb_ibus_ack_o, 0);
    chk("c1_idat", bus.wb_ibus_dat_o, 0);
    tick();
    bus.wb_mem_ack_i = 1'b0;
    bus.wb_dbus_stb_i = 1'b0;
    chk("c_gap", bus.wb_mem_stb_o, 0);
    tick();
    chk("c2_stb", bus.wb_mem_stb_o, 1);
    chk("c2_sel", bus.sel_rom_ram_o, 0);
    chk("c2_adr", bus.wb_mem_adr_o, 32'h80);
    chk("c2_be",  bus.wb_mem_be_o, 4'hF);
    bus.wb_mem_dat_i = 32'hB00B_0002;
    bus.wb_mem_ack_i = 1'b1;
    #1;
    chk("c2_iack", bus.wb_ibus_ack_o, 1);
    chk("c2_idat", bus.wb_ibus_dat_o, 32'hB00B_0002);
    chk("c2_dack", bus.wb_dbus_ack_o, 0);
    tick();
    bus.wb_mem_ack_i = 1'b0;
    bus.wb_ibus_stb_i = 1'b0;
    chk("c2_stb_off", bus.wb_mem_stb_o, 0);
    tick();

    // fetch RAM word, overwrite it from dbus, fetch again must miss
    bus.wb_ibus_stb_i = 1'b1;
    bus.wb_ibus_adr_i = 32'h0100_0020;
    tick();
    chk("i1_sel", bus.sel_rom_ram_o, 1);
    chk("i1_adr", bus.wb_mem_adr_o, 32'h8);
    bus.wb_mem_dat_i = 32'h1111_0008;
    bus.wb_mem_ack_i = 1'b1;
    tick();
    bus.wb_mem_ack_i = 1'b0;
    bus.wb_ibus_stb_i = 1'b0;
    tick();
    bus.wb_dbus_stb_i = 1'b1;
    bus.wb_dbus_we_i  = 1'b1;
    bus.wb_dbus_be_i  = 4'hF;
    bus.wb_dbus_adr_i = 32'h0100_0020;
    bus.wb_dbus_dat_i = 32'h2222_0008;
    tick();
    chk("i2_we",  bus.wb_mem_we_o, 1);
    chk("i2_adr", bus.wb_mem_adr_o, 32'h8);
    bus.wb_mem_ack_i = 1'b1;
    tick();
    bus.wb_mem_ack_i = 1'b0;
    bus.wb_dbus_stb_i = 1'b0;
    bus.wb_dbus_we_i  = 1'b0;
    tick();
    bus.wb_ibus_stb_i = 1'b1;
    bus.wb_ibus_adr_i = 32'h0100_0020;
    tick();
    chk("i3_nohit_ack", bus.wb_ibus_ack_o, 0);
    chk("i3_stb", bus.wb_mem_stb_o, 1);
    bus.wb_mem_dat_i = 32'h2222_0008;
    bus.wb_mem_ack_i = 1'b1;
    #1;
    chk("i3_idat", bus.wb_ibus_dat_o, 32'h2222_0008);
    tick();
    bus.wb_mem_ack_i = 1'b0;
    bus.wb_ibus_stb_i = 1'b0;
    tick();

    // reset in the middle of a downstream access
    bus.wb_ibus_stb_i = 1'b1;
    bus.wb_ibus_adr_i = 32'h0000_0300;
    tick();
    chk("r1_stb", bus.wb_mem_stb_o, 1);
    rst_n = 1'b0;
    tick();
    bus.wb_ibus_stb_i = 1'b0;
    chk("r1_stb_off", bus.wb_mem_stb_o, 0);
    chk("r1_iack", bus.wb_ibus_ack_o, 0);
    chk("r1_err", bus.rom_wr_err_o, 0);
    rst_n = 1'b1;
    tick();
    // previously buffered word must now miss
    bus.wb_ibus_stb_i = 1'b1;
    bus.wb_ibus_adr_i = 32'h0100_0020;
    tick();
    chk("r2_nohit_ack", bus.wb_ibus_ack_o, 0);
    chk("r2_stb", bus.wb_mem_stb_o, 1);
    bus.wb_mem_dat_i = 32'h3333_0008;
    bus.wb_mem_ack_i = 1'b1;
    #1;
    chk("r2_iack", bus.wb_ibus_ack_o, 1);
    tick();
    bus.wb_mem_ack_i = 1'b0;
    bus.wb_ibus_stb_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
